// File: rtl/scv_bus_pkg.sv
// Shared types and address-map constants for the Super Cassette Vision system-bus controller.
package scv_bus_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    ROM  = 3'd1,
    VRAM = 3'd2,
    CART = 3'd3,
    WRAM = 3'd4
  } e_region;

  localparam logic [15:0] ROM_LIMIT  = 16'h0FFF;
  localparam logic [15:0] VRAM_BASE  = 16'h2000;
  localparam logic [15:0] VRAM_LIMIT = 16'h3FFF;
  localparam logic [15:0] WRAM_BASE  = 16'hFF80;
  localparam logic [15:0] CART_BASE  = 16'h8000;
  localparam logic [15:0] CART_LIMIT = 16'hFF7F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_REQ,
    S_WAIT,
    S_DONE
  } e_state;

endpackage

// File: rtl/scv_bus_decode.sv
// Combinational address decoder; the first matching region wins.
module scv_bus_decode
  import scv_bus_pkg::*;
(
  input  logic [15:0] addr,
  output e_region     region
);

  always_comb begin
    // NOTE: default first so every path assigns region and no latch is inferred.
    region = NONE;
    if (addr <= ROM_LIMIT)
      region = ROM;
    else if (addr >= VRAM_BASE && addr <= VRAM_LIMIT)
      region = VRAM;
    else if (addr >= WRAM_BASE)
      region = WRAM;
    else if (addr >= CART_BASE && addr <= CART_LIMIT)
      region = CART;
  end

endmodule

// File: rtl/scv_bus.sv
// uPD7800 system-bus controller: region decode, synchronous-memory read FSM timed
// against the CPU's CP1/CP2 phases, write-strobe to one-cycle pulse, overrun flag.
module scv_bus
  import scv_bus_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CP1_POSEDGE,
  input  logic        CP2_NEGEDGE,
  input  logic [15:0] CPU_A,
  input  logic [7:0]  CPU_DB_O,
  input  logic        CPU_WRB,
  input  logic        CPU_M1,
  output logic [7:0]  CPU_DB_I,
  output logic [15:0] MEM_A,
  output logic [7:0]  MEM_DO,
  output e_region     MEM_SEL,
  output logic        MEM_RD,
  output logic        MEM_WR,
  input  logic [7:0]  ROM_DI,
  input  logic [7:0]  VRAM_DI,
  input  logic [7:0]  CART_DI,
  input  logic [7:0]  WRAM_DI,
  output logic        FETCH,
  output logic        OVERRUN
);

  e_state      state_q, state_d;
  logic [15:0] a_q;
  e_region     sel_q;
  logic        m1_q;
  logic [1:0]  cnt_q;
  logic        wrb_q;
  logic        mem_wr_q;
  logic [15:0] hold_a;
  e_region     hold_sel;
  logic [7:0]  hold_do;
  logic [7:0]  db_q;
  logic        fetch_q;
  logic        overrun_q;

  e_region     wr_region, addr_region;
  logic        wr_edge, rd_req, capture, open_load;
  logic [7:0]  rd_data;

  scv_bus_decode u_wr_decode   (.addr(CPU_A), .region(wr_region));
  scv_bus_decode u_addr_decode (.addr(CPU_A), .region(addr_region));

  assign wr_edge   = wrb_q & ~CPU_WRB;
  // A write edge or a CP1 restart in REQ takes the bus away from the read.
  assign rd_req    = (state_q == S_REQ) && (sel_q != NONE) && !wr_edge && !CP1_POSEDGE;
  assign open_load = (state_q == S_REQ) && (sel_q == NONE) && !wr_edge && !CP1_POSEDGE;
  assign capture   = (state_q == S_WAIT) && !CP1_POSEDGE && (cnt_q == 2'd1);

  always_comb begin
    rd_data = OPEN_BUS;
    case (sel_q)
      ROM:     rd_data = ROM_DI;
      VRAM:    rd_data = VRAM_DI;
      CART:    rd_data = CART_DI;
      WRAM:    rd_data = WRAM_DI;
      default: rd_data = OPEN_BUS;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (CP1_POSEDGE) state_d = S_ADDR;
      S_ADDR:         state_d = CPU_WRB ? S_REQ : S_DONE;
      S_REQ: begin
        if (CP1_POSEDGE)                     state_d = S_ADDR;
        else if (wr_edge || sel_q == NONE)   state_d = S_DONE;
        else                                 state_d = S_WAIT;
      end
      S_WAIT: begin
        if (CP1_POSEDGE)       state_d = S_ADDR;
        else if (cnt_q == 2'd1) state_d = S_DONE;
      end
      default:                state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      sel_q     <= NONE;
      m1_q      <= 1'b0;
      cnt_q     <= '0;
      wrb_q     <= 1'b1;
      mem_wr_q  <= 1'b0;
      hold_a    <= '0;
      hold_sel  <= NONE;
      hold_do   <= '0;
      db_q      <= OPEN_BUS;
      fetch_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wrb_q    <= CPU_WRB;
      mem_wr_q <= wr_edge;

      if (state_q == S_ADDR) begin
        a_q   <= CPU_A;
        sel_q <= addr_region;
        m1_q  <= CPU_M1;
      end

      if (rd_req) begin
        cnt_q    <= 2'(RD_LAT);
        hold_a   <= a_q;
        hold_sel <= sel_q;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 2'd1;
      end

      // The write address/data are presented on the pulse cycle and held afterwards.
      if (wr_edge) begin
        hold_a   <= CPU_A;
        hold_sel <= wr_region;
        hold_do  <= CPU_DB_O;
      end

      if (capture) begin
        db_q    <= rd_data;
        fetch_q <= m1_q;
      end else if (open_load) begin
        db_q <= OPEN_BUS;
      end

      if (CP2_NEGEDGE && (state_q == S_ADDR || state_q == S_REQ || state_q == S_WAIT))
        overrun_q <= 1'b1;
    end
  end

  assign MEM_RD   = rd_req;
  assign MEM_WR   = mem_wr_q;
  assign MEM_A    = rd_req ? a_q   : hold_a;
  assign MEM_SEL  = rd_req ? sel_q : hold_sel;
  assign MEM_DO   = hold_do;
  assign CPU_DB_I = db_q;
  assign FETCH    = fetch_q;
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_scv_bus.sv
// Randomized bench for scv_bus against a region-map and memory-image reference model.
module tb_scv_bus;
  import scv_bus_pkg::*;

  localparam int         RD_LAT   = 1;
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CP1_POSEDGE = 1'b0, CP2_NEGEDGE = 1'b0;
  logic [15:0] CPU_A = '0;
  logic [7:0]  CPU_DB_O = '0;
  logic        CPU_WRB = 1'b1, CPU_M1 = 1'b0;
  logic [7:0]  CPU_DB_I, MEM_DO;
  logic [15:0] MEM_A;
  e_region     MEM_SEL;
  logic        MEM_RD, MEM_WR, FETCH, OVERRUN;
  logic [7:0]  ROM_DI, VRAM_DI, CART_DI, WRAM_DI;

  scv_bus #(.RD_LAT(RD_LAT), .OPEN_BUS(OPEN_BUS)) dut (
    .CLK(CLK), .RESET(RESET), .CP1_POSEDGE(CP1_POSEDGE), .CP2_NEGEDGE(CP2_NEGEDGE),
    .CPU_A(CPU_A), .CPU_DB_O(CPU_DB_O), .CPU_WRB(CPU_WRB), .CPU_M1(CPU_M1),
    .CPU_DB_I(CPU_DB_I), .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_SEL(MEM_SEL),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .ROM_DI(ROM_DI), .VRAM_DI(VRAM_DI),
    .CART_DI(CART_DI), .WRAM_DI(WRAM_DI), .FETCH(FETCH), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int both_seen = 0;
  logic [7:0] exp_db;
  logic       exp_fetch;
  logic       exp_overrun;
  logic [7:0] mem_img [logic [18:0]];

  // Memory contents are random but stable per (region, address).
  function automatic logic [7:0] mem_read(e_region r, logic [15:0] a);
    logic [18:0] key = {r, a};
    if (!mem_img.exists(key)) mem_img[key] = 8'($urandom);
    return mem_img[key];
  endfunction

  function automatic e_region ref_region(logic [15:0] a);
    if (a < 16'h1000) return ROM;
    if (a >= 16'h2000 && a < 16'h4000) return VRAM;
    if (a >= 16'hFF80) return WRAM;
    if (a >= 16'h8000) return CART;
    return NONE;
  endfunction

  function automatic logic [15:0] pick_addr();
    logic [15:0] pool [10] = '{16'h0FFF, 16'h1000, 16'h1FFF, 16'h2000, 16'h3FFF,
                               16'h4000, 16'h7FFF, 16'h8000, 16'hFF7F, 16'hFF80};
    if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 9)];
    return 16'($urandom);
  endfunction

  // Synchronous memories: data for a request appears RD_LAT cycles later, noise otherwise.
  logic [7:0] di_pipe [RD_LAT][4];
  always @(posedge CLK) begin
    for (int r = 0; r < 4; r++) begin
      if (MEM_RD && MEM_SEL == e_region'(r + 1))
        di_pipe[0][r] <= mem_read(e_region'(r + 1), MEM_A);
      else
        di_pipe[0][r] <= 8'($urandom);
      for (int s = 1; s < RD_LAT; s++) di_pipe[s][r] <= di_pipe[s-1][r];
    end
  end
  assign ROM_DI  = di_pipe[RD_LAT-1][0];
  assign VRAM_DI = di_pipe[RD_LAT-1][1];
  assign CART_DI = di_pipe[RD_LAT-1][2];
  assign WRAM_DI = di_pipe[RD_LAT-1][3];

  always @(negedge CLK) if (MEM_RD && MEM_WR) both_seen <= both_seen + 1;

  // One CPU read bus cycle; k counts cycles from the CP1 strobe (k=0 is cycle n).
  task automatic run_read(input logic [15:0] addr, input logic m1, input int cp2_at,
                          output int rd_count, output int rd_cycle, output logic [15:0] rd_a,
                          output e_region rd_sel, output logic [7:0] db_early,
                          output logic [7:0] db_valid);
    rd_count = 0; rd_cycle = -1; rd_a = '0; rd_sel = NONE; db_early = '0; db_valid = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      CP1_POSEDGE = (k == 0);
      CP2_NEGEDGE = (k == cp2_at) && (k != 0);
      CPU_A       = (k == 0) ? 16'($urandom) : addr;
      CPU_M1      = (k == 0) ? 1'($urandom) : m1;
      CPU_WRB     = 1'b1;
      @(negedge CLK);
      if (MEM_RD) begin rd_count++; rd_cycle = k; rd_a = MEM_A; rd_sel = MEM_SEL; end
      if (k == 2 + RD_LAT) db_early = CPU_DB_I;
      if (k == 3 + RD_LAT) db_valid = CPU_DB_I;
    end
  endtask

  // One CPU write bus cycle with CPU_WRB held low for 'low' cycles from k=1.
  task automatic run_write(input logic [15:0] addr, input logic [7:0] data, input int low,
                           output int wr_count, output int wr_cycle, output logic [15:0] wa,
                           output logic [7:0] wdo, output e_region wsel);
    wr_count = 0; wr_cycle = -1; wa = '0; wdo = '0; wsel = NONE;
    for (int k = 0; k < low + 4; k++) begin
      @(posedge CLK); #1;
      CP1_POSEDGE = (k == 0);
      CP2_NEGEDGE = 1'b0;
      CPU_A       = (k == 0) ? 16'($urandom) : addr;
      CPU_DB_O    = (k == 0) ? 8'($urandom) : data;
      CPU_WRB     = !(k >= 1 && k <= low);
      @(negedge CLK);
      if (MEM_WR) begin wr_count++; wr_cycle = k; wa = MEM_A; wdo = MEM_DO; wsel = MEM_SEL; end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (CPU_DB_I !== OPEN_BUS) begin
      errors++; $display("FAIL reset_db: got %h expected %h", CPU_DB_I, OPEN_BUS);
    end
    checks++;
    if ({MEM_RD, MEM_WR, MEM_A, MEM_DO, MEM_SEL, FETCH, OVERRUN} !== {2'b00, 16'h0, 8'h0, NONE, 2'b00}) begin
      errors++; $display("FAIL reset_outputs: got rd=%b wr=%b a=%h do=%h sel=%0d fetch=%b ovr=%b expected all zero/NONE",
                         MEM_RD, MEM_WR, MEM_A, MEM_DO, MEM_SEL, FETCH, OVERRUN);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    exp_db = OPEN_BUS; exp_fetch = 1'b0; exp_overrun = 1'b0;
  endtask

  task automatic test_rom_read();
    int n_rd, c_rd; logic [15:0] a; e_region s; logic [7:0] early, valid;
    logic [7:0] prev = exp_db;
    mem_img[{ROM, 16'h0123}] = 8'h5A;
    run_read(16'h0123, 1'b1, 5, n_rd, c_rd, a, s, early, valid);
    exp_db = 8'h5A; exp_fetch = 1'b1;
    checks++; if (n_rd !== 1)  begin errors++; $display("FAIL rom_rd_count: got %0d expected 1", n_rd); end
    checks++; if (c_rd !== 2)  begin errors++; $display("FAIL rom_rd_cycle: got n+%0d expected n+2", c_rd); end
    checks++; if (a !== 16'h0123 || s !== ROM) begin
      errors++; $display("FAIL rom_rd_addr: got %h/%0d expected 0123/%0d", a, s, ROM); end
    checks++; if (early !== prev) begin errors++; $display("FAIL rom_db_early: got %h expected %h", early, prev); end
    checks++; if (valid !== exp_db) begin errors++; $display("FAIL rom_db: got %h expected %h", valid, exp_db); end
    checks++; if (FETCH !== exp_fetch) begin errors++; $display("FAIL rom_fetch: got %b expected %b", FETCH, exp_fetch); end
    checks++; if (OVERRUN !== exp_overrun) begin errors++; $display("FAIL rom_overrun: got %b expected %b", OVERRUN, exp_overrun); end
  endtask

  task automatic test_unmapped();
    int n_rd, c_rd; logic [15:0] a; e_region s; logic [7:0] early, valid;
    run_read(16'h5000, 1'b0, 5, n_rd, c_rd, a, s, early, valid);
    exp_db = OPEN_BUS;
    checks++; if (n_rd !== 0) begin errors++; $display("FAIL open_rd_count: got %0d expected 0", n_rd); end
    checks++; if (valid !== exp_db) begin errors++; $display("FAIL open_db: got %h expected %h", valid, exp_db); end
    checks++; if (FETCH !== exp_fetch) begin errors++; $display("FAIL open_fetch: got %b expected %b", FETCH, exp_fetch); end
  endtask

  task automatic test_write();
    int n_wr, c_wr; logic [15:0] a; logic [7:0] d; e_region s;
    run_write(16'hFF90, 8'h3C, 3, n_wr, c_wr, a, d, s);
    checks++; if (n_wr !== 1) begin errors++; $display("FAIL wr_count: got %0d expected 1", n_wr); end
    checks++; if (c_wr !== 2) begin errors++; $display("FAIL wr_cycle: got n+%0d expected n+2", c_wr); end
    checks++; if (a !== 16'hFF90 || d !== 8'h3C || s !== WRAM) begin
      errors++; $display("FAIL wr_bus: got %h/%h/%0d expected ff90/3c/%0d", a, d, s, WRAM); end
    checks++; if (CPU_DB_I !== exp_db) begin errors++; $display("FAIL wr_db: got %h expected %h", CPU_DB_I, exp_db); end
    checks++; if (MEM_A !== 16'hFF90 || MEM_DO !== 8'h3C || MEM_SEL !== WRAM) begin
      errors++; $display("FAIL wr_hold: got %h/%h/%0d expected ff90/3c/%0d", MEM_A, MEM_DO, MEM_SEL, WRAM); end
  endtask

  task automatic test_boundaries();
    logic [15:0] addrs [4] = '{16'hFF7F, 16'hFF80, 16'h1FFF, 16'h2000};
    int n_rd, c_rd; logic [15:0] a; e_region s; logic [7:0] early, valid;
    for (int i = 0; i < 4; i++) begin
      e_region r = ref_region(addrs[i]);
      run_read(addrs[i], 1'b0, 3 + RD_LAT, n_rd, c_rd, a, s, early, valid);
      exp_db = (r == NONE) ? OPEN_BUS : mem_read(r, addrs[i]);
      if (r != NONE) exp_fetch = 1'b0;
      checks++; if (n_rd !== ((r == NONE) ? 0 : 1) || (r != NONE && s !== r)) begin
        errors++; $display("FAIL bound_sel %h: got count=%0d sel=%0d expected sel=%0d", addrs[i], n_rd, s, r); end
      checks++; if (valid !== exp_db) begin
        errors++; $display("FAIL bound_db %h: got %h expected %h", addrs[i], valid, exp_db); end
    end
    checks++; if (OVERRUN !== exp_overrun) begin errors++; $display("FAIL bound_overrun: got %b expected %b", OVERRUN, exp_overrun); end
  endtask

  // Write edge lands in the REQ cycle: the write wins and the read is dropped.
  task automatic test_write_vs_read();
    int n_rd = 0, n_wr = 0, c_wr = -1;
    for (int k = 0; k < 7; k++) begin
      @(posedge CLK); #1;
      CP1_POSEDGE = (k == 0);
      CPU_A       = 16'h8456;
      CPU_DB_O    = 8'hA7;
      CPU_WRB     = !(k >= 2 && k <= 3);
      @(negedge CLK);
      if (MEM_RD) n_rd++;
      if (MEM_WR) begin n_wr++; c_wr = k; end
    end
    checks++; if (n_rd !== 0) begin errors++; $display("FAIL wvr_rd: got %0d read strobes expected 0", n_rd); end
    checks++; if (n_wr !== 1 || c_wr !== 3) begin
      errors++; $display("FAIL wvr_wr: got %0d pulses at n+%0d expected 1 at n+3", n_wr, c_wr); end
    checks++; if (CPU_DB_I !== exp_db) begin errors++; $display("FAIL wvr_db: got %h expected %h", CPU_DB_I, exp_db); end
  endtask

  task automatic test_random();
    int n, c; logic [15:0] a, ga; logic [7:0] d, gd, early, valid; e_region s; logic m1;
    for (int i = 0; i < 40; i++) begin
      a = pick_addr();
      if ($urandom_range(0, 2) == 0) begin
        d = 8'($urandom);
        run_write(a, d, $urandom_range(1, 4), n, c, ga, gd, s);
        checks++; if (n !== 1 || ga !== a || gd !== d || s !== ref_region(a)) begin
          errors++; $display("FAIL rnd_wr %0d: got n=%0d %h/%h/%0d expected 1 %h/%h/%0d",
                             i, n, ga, gd, s, a, d, ref_region(a)); end
      end else begin
        m1 = 1'($urandom);
        run_read(a, m1, $urandom_range(3 + RD_LAT, 7), n, c, ga, s, early, valid);
        if (ref_region(a) != NONE) begin
          exp_db = mem_read(ref_region(a), a); exp_fetch = m1;
        end else begin
          exp_db = OPEN_BUS;
        end
        checks++; if (n !== ((ref_region(a) == NONE) ? 0 : 1)) begin
          errors++; $display("FAIL rnd_rd_count %0d @%h: got %0d", i, a, n); end
        checks++; if (valid !== exp_db || FETCH !== exp_fetch) begin
          errors++; $display("FAIL rnd_rd %0d @%h: got %h/%b expected %h/%b", i, a, valid, FETCH, exp_db, exp_fetch); end
      end
      checks++; if (CPU_DB_I !== exp_db) begin errors++; $display("FAIL rnd_db %0d: got %h expected %h", i, CPU_DB_I, exp_db); end
    end
    checks++; if (OVERRUN !== exp_overrun) begin errors++; $display("FAIL rnd_overrun: got %b expected %b", OVERRUN, exp_overrun); end
  endtask

  task automatic test_overrun();
    int n, c; logic [15:0] a; e_region s; logic [7:0] early, valid;
    run_read(16'h8123, 1'b0, 3, n, c, a, s, early, valid);
    exp_overrun = 1'b1; exp_db = mem_read(CART, 16'h8123); exp_fetch = 1'b0;
    checks++; if (OVERRUN !== exp_overrun) begin errors++; $display("FAIL ovr_set: got %b expected 1", OVERRUN); end
    run_read(16'h0042, 1'b1, 6, n, c, a, s, early, valid);
    exp_db = mem_read(ROM, 16'h0042); exp_fetch = 1'b1;
    checks++; if (OVERRUN !== exp_overrun) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", OVERRUN); end
    checks++; if (valid !== exp_db) begin errors++; $display("FAIL ovr_db: got %h expected %h", valid, exp_db); end
  endtask

  task automatic test_reset_mid_read();
    int n_rd = 0, n_wr = 0, c; logic [15:0] a; e_region s; logic [7:0] early, valid;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      CP1_POSEDGE = (k == 0);
      CPU_A = 16'h2345; CPU_WRB = 1'b1;
    end
    #2 RESET = 1'b1;
    @(negedge CLK);
    exp_db = OPEN_BUS; exp_fetch = 1'b0; exp_overrun = 1'b0;
    checks++; if ({MEM_RD, MEM_WR, CPU_DB_I, FETCH, OVERRUN} !== {2'b00, OPEN_BUS, 2'b00}) begin
      errors++; $display("FAIL midrst: got rd=%b wr=%b db=%h fetch=%b ovr=%b expected 0 0 %h 0 0",
                         MEM_RD, MEM_WR, CPU_DB_I, FETCH, OVERRUN, OPEN_BUS); end
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (MEM_RD) n_rd++;
      if (MEM_WR) n_wr++;
    end
    checks++; if (n_rd !== 0 || n_wr !== 0) begin
      errors++; $display("FAIL midrst_idle: got %0d reads %0d writes expected none", n_rd, n_wr); end
    run_read(16'h2345, 1'b1, 5, n_rd, c, a, s, early, valid);
    exp_db = mem_read(VRAM, 16'h2345); exp_fetch = 1'b1;
    checks++; if (n_rd !== 1 || valid !== exp_db || FETCH !== exp_fetch) begin
      errors++; $display("FAIL midrst_next: got n=%0d db=%h fetch=%b expected 1 %h 1", n_rd, valid, FETCH, exp_db); end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (both_seen !== 0) begin errors++; $display("FAIL rd_wr_overlap: got %0d cycles expected 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_unmapped();
    test_write();
    test_boundaries();
    test_write_vs_read();
    test_random();
    test_overrun();
    test_reset_mid_read();
    test_no_overlap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
